// File: rtl/mem_arb_n.sv
// mem_arb_n: arbitrates one store and NUM_RD read clients onto a byte-wide RAM port.
// Define MEM_ARB_RR_EN for round-robin read grant; default build is fixed priority (lowest index wins).
module mem_arb_n #(
  parameter int NUM_RD = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clear_flag_in,
  input  logic [NUM_RD-1:0]        rd_req_in,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_in,
  input  logic [NUM_RD*2-1:0]      rd_len_in,
  output logic [NUM_RD-1:0]        rd_valid_out,
  output logic [31:0]              rd_data_out,
  input  logic                     wr_req_in,
  input  logic [ADDR_W-1:0]        wr_addr_in,
  input  logic [1:0]               wr_len_in,
  input  logic [31:0]              wr_data_in,
  output logic                     wr_done_out,
  output logic                     ram_rw_select_out,
  output logic [ADDR_W-1:0]        ram_addr_out,
  output logic [7:0]               ram_data_out,
  input  logic [7:0]               ram_data_in
);
  localparam int CLI_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [1:0]        r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [CLI_W-1:0]  r_client, w_client_nxt;
  logic [31:0]       r_acc, w_acc_nxt;
  logic [23:0]       r_wbuf, w_wbuf_nxt;
  logic [NUM_RD-1:0] r_rd_valid, w_rd_valid_nxt;
  logic [31:0]       r_rd_data, w_rd_data_nxt;
  logic              r_wr_done, w_wr_done_nxt;
  logic              r_ram_rw, w_ram_rw_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [7:0]        r_ram_data, w_ram_data_nxt;

  logic [NUM_RD-1:0] r_rd_pend;
  logic [ADDR_W-1:0] r_rd_addr [NUM_RD];
  logic [1:0]        r_rd_len  [NUM_RD];
  logic              r_wr_pend;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_wr_len;
  logic [31:0]       r_wr_data;

  logic [NUM_RD-1:0] w_rd_acc, w_rd_cand;
  logic              w_wr_acc, w_wr_cand;
  logic              w_rd_any;
  logic [CLI_W-1:0]  w_rd_sel;
  logic              w_rd_grant, w_wr_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [1:0]        w_sel_len;
  logic [ADDR_W-1:0] w_wr_eff_addr;
  logic [1:0]        w_wr_eff_len;
  logic [31:0]       w_wr_eff_data;
  logic [1:0]        w_cap_idx;
  logic [31:0]       w_acc_cap;

  assign rd_valid_out      = r_rd_valid;
  assign rd_data_out       = r_rd_data;
  assign wr_done_out       = r_wr_done;
  assign ram_rw_select_out = r_ram_rw;
  assign ram_addr_out      = r_ram_addr;
  assign ram_data_out      = r_ram_data;

  // A request joins arbitration in its own cycle, so a client re-requesting on its completion cycle competes at once
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_acc[i] = rd_req_in[i] && !r_rd_pend[i] && !clear_flag_in &&
                    !((r_state == ST_READ) && (r_client == CLI_W'(i)));
    end
    w_rd_cand     = clear_flag_in ? '0 : (r_rd_pend | w_rd_acc);
    w_wr_acc      = wr_req_in && !r_wr_pend && (r_state != ST_WRITE);
    w_wr_cand     = r_wr_pend | w_wr_acc;
    w_wr_eff_addr = r_wr_pend ? r_wr_addr : wr_addr_in;
    w_wr_eff_len  = r_wr_pend ? r_wr_len  : wr_len_in;
    w_wr_eff_data = r_wr_pend ? r_wr_data : wr_data_in;
  end

`ifdef MEM_ARB_RR_EN
  logic [CLI_W-1:0] r_rr_ptr;
  int               v_idx;

  // Round-robin search starting at r_rr_ptr
  always_comb begin
    w_rd_any = 1'b0;
    w_rd_sel = '0;
    v_idx    = 0;
    for (int k = 0; k < NUM_RD; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_RD;
      if (!w_rd_any && w_rd_cand[v_idx]) begin
        w_rd_any = 1'b1;
        w_rd_sel = CLI_W'(v_idx);
      end else begin
        w_rd_any = w_rd_any;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (rdy && w_rd_grant) begin
      r_rr_ptr <= (w_rd_sel == CLI_W'(NUM_RD - 1)) ? '0 : w_rd_sel + CLI_W'(1);
    end
  end
`else
  // Fixed priority: scan downwards so the lowest pending index is the last writer
  always_comb begin
    w_rd_any = 1'b0;
    w_rd_sel = '0;
    for (int k = NUM_RD - 1; k >= 0; k--) begin
      if (w_rd_cand[k]) begin
        w_rd_any = 1'b1;
        w_rd_sel = CLI_W'(k);
      end else begin
        w_rd_any = w_rd_any;
      end
    end
  end
`endif

  always_comb begin
    w_wr_grant = (r_state == ST_IDLE) && w_wr_cand;
    w_rd_grant = (r_state == ST_IDLE) && !w_wr_cand && w_rd_any;
    w_sel_addr = r_rd_pend[w_rd_sel] ? r_rd_addr[w_rd_sel] : rd_addr_in[w_rd_sel*ADDR_W +: ADDR_W];
    w_sel_len  = r_rd_pend[w_rd_sel] ? r_rd_len[w_rd_sel]  : rd_len_in[w_rd_sel*2 +: 2];
    w_cap_idx  = r_cnt[1:0] - 2'd1;
    w_acc_cap  = r_acc;
    w_acc_cap[{w_cap_idx, 3'b000} +: 8] = ram_data_in;
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_len_nxt      = r_len;
    w_addr_nxt     = r_addr;
    w_client_nxt   = r_client;
    w_acc_nxt      = r_acc;
    w_wbuf_nxt     = r_wbuf;
    w_rd_valid_nxt = '0;
    w_rd_data_nxt  = r_rd_data;
    w_wr_done_nxt  = 1'b0;
    w_ram_rw_nxt   = 1'b0;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_data_nxt = r_ram_data;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_grant) begin
          w_state_nxt    = ST_WRITE;
          w_ram_rw_nxt   = 1'b1;
          w_ram_addr_nxt = w_wr_eff_addr;
          w_ram_data_nxt = w_wr_eff_data[7:0];
          w_wbuf_nxt     = w_wr_eff_data[31:8];
          w_addr_nxt     = w_wr_eff_addr + ADDR_W'(1);
          w_len_nxt      = w_wr_eff_len;
          w_cnt_nxt      = 3'd0;
        end else if (w_rd_grant) begin
          w_state_nxt    = ST_READ;
          w_ram_addr_nxt = w_sel_addr;
          w_addr_nxt     = w_sel_addr + ADDR_W'(1);
          w_len_nxt      = w_sel_len;
          w_client_nxt   = w_rd_sel;
          w_acc_nxt      = 32'h0000_0000;
          w_cnt_nxt      = 3'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        // r_cnt counts cycles in READ; byte r_cnt-1 arrives on ram_data_in this cycle
        if (clear_flag_in) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == ({1'b0, r_len} + 3'd1)) begin
          w_state_nxt              = ST_IDLE;
          w_rd_valid_nxt[r_client] = 1'b1;
          w_rd_data_nxt            = w_acc_cap;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt != 3'd0) begin
            w_acc_nxt = w_acc_cap;
          end else begin
            w_acc_nxt = r_acc;
          end
          if (r_cnt < {1'b0, r_len}) begin
            w_ram_addr_nxt = r_addr;
            w_addr_nxt     = r_addr + ADDR_W'(1);
          end else begin
            w_ram_addr_nxt = r_ram_addr;
          end
        end
      end
      ST_WRITE: begin
        if (r_cnt[1:0] == r_len) begin
          w_state_nxt   = ST_IDLE;
          w_wr_done_nxt = 1'b1;
        end else begin
          w_ram_rw_nxt   = 1'b1;
          w_ram_addr_nxt = r_addr;
          w_addr_nxt     = r_addr + ADDR_W'(1);
          w_ram_data_nxt = r_wbuf[7:0];
          w_wbuf_nxt     = {8'h00, r_wbuf[23:8]};
          w_cnt_nxt      = r_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_len      <= 2'd0;
      r_addr     <= '0;
      r_client   <= '0;
      r_acc      <= 32'h0000_0000;
      r_wbuf     <= 24'h00_0000;
      r_rd_valid <= '0;
      r_rd_data  <= 32'h0000_0000;
      r_wr_done  <= 1'b0;
      r_ram_rw   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= 8'h00;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_addr     <= w_addr_nxt;
      r_client   <= w_client_nxt;
      r_acc      <= w_acc_nxt;
      r_wbuf     <= w_wbuf_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_wr_done  <= w_wr_done_nxt;
      r_ram_rw   <= w_ram_rw_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_data <= w_ram_data_nxt;
    end
  end

  // Pending bits and request parameters captured at the request pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= '0;
      for (int i = 0; i < NUM_RD; i++) begin
        r_rd_addr[i] <= '0;
        r_rd_len[i]  <= 2'd0;
      end
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
      r_wr_len  <= 2'd0;
      r_wr_data <= 32'h0000_0000;
    end else if (rdy) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (w_rd_acc[i]) begin
          r_rd_addr[i] <= rd_addr_in[i*ADDR_W +: ADDR_W];
          r_rd_len[i]  <= rd_len_in[i*2 +: 2];
        end
        if (clear_flag_in) begin
          r_rd_pend[i] <= 1'b0;
        end else if (w_rd_grant && (w_rd_sel == CLI_W'(i))) begin
          r_rd_pend[i] <= 1'b0;
        end else if (w_rd_acc[i]) begin
          r_rd_pend[i] <= 1'b1;
        end
      end
      if (w_wr_acc) begin
        r_wr_addr <= wr_addr_in;
        r_wr_len  <= wr_len_in;
        r_wr_data <= wr_data_in;
      end
      if (w_wr_grant) begin
        r_wr_pend <= 1'b0;
      end else if (w_wr_acc) begin
        r_wr_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb_n.sv
// Scoreboard bench for mem_arb_n: expected completions are queued at stimulus time and matched on output.
module tb_mem_arb_n;
  localparam int NUM_RD = 2;
  localparam int ADDR_W = 32;

  logic                     clk = 1'b0;
  logic                     rst, rdy, clear_flag_in;
  logic [NUM_RD-1:0]        rd_req_in;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_in;
  logic [NUM_RD*2-1:0]      rd_len_in;
  logic [NUM_RD-1:0]        rd_valid_out;
  logic [31:0]              rd_data_out;
  logic                     wr_req_in;
  logic [ADDR_W-1:0]        wr_addr_in;
  logic [1:0]               wr_len_in;
  logic [31:0]              wr_data_in;
  logic                     wr_done_out;
  logic                     ram_rw_select_out;
  logic [ADDR_W-1:0]        ram_addr_out;
  logic [7:0]               ram_data_out;
  logic [7:0]               ram_data_in = 8'h00;

  mem_arb_n #(.NUM_RD(NUM_RD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear_flag_in),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_len_in(rd_len_in),
    .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_len_in(wr_len_in),
    .wr_data_in(wr_data_in), .wr_done_out(wr_done_out),
    .ram_rw_select_out(ram_rw_select_out), .ram_addr_out(ram_addr_out),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 4 KiB window on the low address bits, one-cycle read latency
  logic [7:0]  mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'h000;
  logic [7:0]  pl_data = 8'h00;
  always @(posedge clk) begin
    if (ram_rw_select_out) mem[ram_addr_out[11:0]] <= ram_data_out;
    else if (pl_en) mem[pl_addr] <= pl_data;
    ram_data_in <= mem[ram_addr_out[11:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    int          client;
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      wr_q[$];

  always @(negedge clk) begin
    rd_exp_t e;
    int      wc;
    if (rd_valid_out != '0) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 64'(rd_valid_out), 64'd0);
      end else begin
        e = rd_q.pop_front();
        check("rd_client", 64'(rd_valid_out), 64'd1 << e.client);
        check("rd_data", 64'(rd_data_out), 64'(e.data));
        if (e.cyc >= 0) check("rd_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (wr_done_out) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 64'd1, 64'd0);
      end else begin
        wc = wr_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(wc));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req_in     = '0;
    wr_req_in     = 1'b0;
    clear_flag_in = 1'b0;
  endtask

  task automatic set_rd(input int cl, input logic [31:0] a, input logic [1:0] l);
    rd_req_in[cl]          = 1'b1;
    rd_addr_in[cl*32 +: 32] = a;
    rd_len_in[cl*2 +: 2]    = l;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    wr_req_in  = 1'b1;
    wr_addr_in = a;
    wr_len_in  = l;
    wr_data_in = d;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rd_q.size() == 0 && wr_q.size() == 0) break;
      tick();
    end
  endtask

  task automatic drain(input int budget);
    wait_empty(budget);
    check("drain", 64'(rd_q.size() + wr_q.size()), 64'd0);
    rd_q.delete();
    wr_q.delete();
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; rdy = 1'b1; clear_flag_in = 1'b0;
    rd_req_in = '0; rd_addr_in = '0; rd_len_in = '0;
    wr_req_in = 1'b0; wr_addr_in = '0; wr_len_in = 2'd0; wr_data_in = 32'h0;
    repeat (3) tick();
    check("rst_rd_valid", 64'(rd_valid_out), 64'd0);
    check("rst_rd_data", 64'(rd_data_out), 64'd0);
    check("rst_wr_done", 64'(wr_done_out), 64'd0);
    check("rst_rw", 64'(ram_rw_select_out), 64'd0);
    check("rst_ram_addr", 64'(ram_addr_out), 64'd0);
    check("rst_ram_data", 64'(ram_data_out), 64'd0);
    preload(12'h100, 8'h11); preload(12'h101, 8'h22);
    preload(12'h102, 8'h33); preload(12'h103, 8'h44);
    preload(12'h300, 8'h5A); preload(12'h310, 8'hA5);
    preload(12'hFFF, 8'hAA); preload(12'h000, 8'hBB);

    // word read issued in the first cycle after reset release
    rst = 1'b0;
    c = cyc;
    set_rd(0, 32'h0000_0100, 2'd3);
    rd_q.push_back('{client: 0, data: 32'h4433_2211, cyc: c + 6});
    tick(); idle_inputs(); drain(40);

    // store and byte read to the same address in one cycle: store goes first
    c = cyc;
    set_wr(32'h0000_0040, 2'd3, 32'hDEAD_BEEF);
    set_rd(1, 32'h0000_0040, 2'd0);
    wr_q.push_back(c + 5);
    rd_q.push_back('{client: 1, data: 32'h0000_00EF, cyc: c + 8});
    tick(); idle_inputs(); drain(40);

    // half read wrapping the address space
    c = cyc;
    set_rd(0, 32'hFFFF_FFFF, 2'd1);
    rd_q.push_back('{client: 0, data: 32'h0000_BBAA, cyc: c + 4});
    tick(); idle_inputs(); drain(40);

    // three-cycle freeze in the middle of a word store
    c = cyc;
    set_wr(32'h0000_0200, 2'd3, 32'hCAFE_F00D);
    wr_q.push_back(c + 8);
    tick(); idle_inputs();
    tick(); rdy = 1'b0;
    tick(); tick();
    check("frz_addr", 64'(ram_addr_out), 64'h201);
    check("frz_rw", 64'(ram_rw_select_out), 64'd1);
    check("frz_data", 64'(ram_data_out), 64'hF0);
    tick(); rdy = 1'b1;
    drain(40);
    check("mem_200", 64'(mem[12'h200]), 64'h0D);
    check("mem_201", 64'(mem[12'h201]), 64'hF0);
    check("mem_202", 64'(mem[12'h202]), 64'hFE);
    check("mem_203", 64'(mem[12'h203]), 64'hCA);

    // flush during a read with a store waiting behind it
    c = cyc;
    set_rd(0, 32'h0000_0100, 2'd3);
    tick(); idle_inputs();
    set_wr(32'h0000_0060, 2'd3, 32'h0102_0304);
    wr_q.push_back(c + 8);
    tick(); idle_inputs(); clear_flag_in = 1'b1;
    tick(); clear_flag_in = 1'b0;
    drain(40);
    check("mem_060", 64'(mem[12'h060]), 64'h04);
    check("mem_061", 64'(mem[12'h061]), 64'h03);
    check("mem_062", 64'(mem[12'h062]), 64'h02);
    check("mem_063", 64'(mem[12'h063]), 64'h01);

    // flush coincident with requests: read dropped, store taken
    c = cyc;
    set_rd(0, 32'h0000_0100, 2'd0);
    set_wr(32'h0000_0050, 2'd0, 32'h0000_0077);
    clear_flag_in = 1'b1;
    wr_q.push_back(c + 2);
    tick(); idle_inputs(); drain(40);
    check("mem_050", 64'(mem[12'h050]), 64'h77);

    // reset in the middle of a read abandons it silently
    set_rd(0, 32'h0000_0100, 2'd3);
    tick(); idle_inputs();
    tick(); tick(); rst = 1'b1;
    tick();
    check("mrst_rd_valid", 64'(rd_valid_out), 64'd0);
    check("mrst_ram_addr", 64'(ram_addr_out), 64'd0);
    check("mrst_rw", 64'(ram_rw_select_out), 64'd0);
    rst = 1'b0;
    repeat (8) tick();

    // two clients requesting continuously
    c = cyc;
    set_rd(0, 32'h0000_0300, 2'd0);
    set_rd(1, 32'h0000_0310, 2'd0);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      if (k % 2 == 0) rd_q.push_back('{client: 0, data: 32'h0000_005A, cyc: c + 3 * (k + 1)});
      else            rd_q.push_back('{client: 1, data: 32'h0000_00A5, cyc: c + 3 * (k + 1)});
`else
      rd_q.push_back('{client: 0, data: 32'h0000_005A, cyc: c + 3 * (k + 1)});
`endif
    end
    wait_empty(60);
    rd_req_in = '0;
    clear_flag_in = 1'b1;
    tick(); clear_flag_in = 1'b0;
    drain(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arb_n.md
MEM_ARB_N -- requirements
Module: mem_arb_n

Interface
REQ-001 Parameter NUM_RD, default 2: number of read clients, range 1..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global ready; low = freeze all state.
REQ-006 clear_flag_in  input  1  pipeline flush (mispredict).
REQ-007 rd_req_in  input  NUM_RD  per-client read request pulse.
REQ-008 rd_addr_in  input  NUM_RD*ADDR_W  per-client byte address; client i at slice i.
REQ-009 rd_len_in  input  NUM_RD*2  per-client length, bytes-1 (0=byte, 1=half, 3=word, 2=3 bytes).
REQ-010 rd_valid_out  output  NUM_RD  one-cycle completion pulse per client.
REQ-011 rd_data_out  output  32  shared read data, valid only with a rd_valid_out bit.
REQ-012 wr_req_in  input  1  store request pulse.
REQ-013 wr_addr_in / wr_len_in / wr_data_in  input  ADDR_W / 2 / 32  store address, length (bytes-1), data.
REQ-014 wr_done_out  output  1  one-cycle store completion pulse.
REQ-015 ram_rw_select_out  output  1  1=write, 0=read.
REQ-016 ram_addr_out / ram_data_out  output  ADDR_W / 8  RAM byte address / write byte.
REQ-017 ram_data_in  input  8  RAM read byte, valid one cycle after its address.

Function
REQ-018 Each client has one pending bit, set on its req pulse; address, length and data SHALL be latched at the req pulse, not sampled later.
REQ-019 A req on a client already pending or in service SHALL be ignored.
REQ-020 States: IDLE, READ, WRITE; grant SHALL occur only in IDLE, the pending store taking priority over all reads.
REQ-021 Read arbitration SHALL follow REQ-036.
REQ-022 Grant in cycle G: byte k (k=0..L-1, L=len+1) address driven in cycle G+1+k.
REQ-023 Read: byte k captured from ram_data_in in cycle G+2+k into bits [8k+7:8k]; unread upper bytes zero.
REQ-024 Read: rd_data_out and rd_valid_out[i] asserted in cycle G+L+2; state returns to IDLE in the same cycle.
REQ-025 Write: ram_rw_select_out=1 with byte k in cycle G+1+k; wr_done_out pulses and rw returns to 0 in cycle G+L+1.
REQ-026 The earliest next grant SHALL be the cycle a completion pulse is asserted, so there is no dead IDLE cycle beyond that one.
REQ-027 ram_rw_select_out SHALL be 0 whenever not in WRITE.
REQ-028 clear_flag_in (with rdy high) SHALL abort any in-flight read, drop all read pending bits, and suppress that read's rd_valid_out.
REQ-029 clear_flag_in SHALL NOT affect a pending or in-flight store; the store completes normally.
REQ-030 A rd_req_in coincident with clear_flag_in SHALL be dropped; a coincident wr_req_in SHALL be accepted.
REQ-031 rdy low: every register holds, including counters, pending bits and RAM outputs; req pulses in that cycle are ignored.
REQ-032 Address increments modulo 2^ADDR_W; a wrap from all-ones to 0 is legal.

Reset
REQ-033 rst SHALL force state IDLE, all pending bits 0, rd_valid_out=0, wr_done_out=0, rd_data_out=0, ram_rw_select_out=0, ram_addr_out=0, ram_data_out=0.
REQ-034 rst SHALL take precedence over rdy and clear_flag_in, and mid-transaction SHALL abandon that transaction with no completion pulse.
REQ-035 The first grant SHALL be possible in the cycle after rst deasserts.

Configuration
REQ-036 Macro MEM_ARB_RR_EN defined: read grant SHALL be round-robin, starting from the client after the last granted one (pointer resets to client 0). Macro undefined: fixed priority, with the lowest index winning.

Verification
REQ-037 Reset, then client0 word read at 0x100 (RAM bytes 11,22,33,44) -> rd_valid_out[0] at G+6, rd_data_out=0x44332211.
REQ-038 Store word 0xDEADBEEF at 0x40 while client1 requests a byte at 0x40 in the same cycle -> store first (wr_done_out at G+5), then rd_data_out=0x000000EF.
REQ-039 Clients 0 and 1 request continuously, NUM_RD=2 -> with MEM_ARB_RR_EN the grants alternate 0,1,0,1; without it client 0 gets every grant.
REQ-040 clear_flag_in in the third cycle of a client0 word read, with a store pending -> no rd_valid_out, the store completes, and RAM is correct.
REQ-041 rdy low for 3 cycles mid-write -> outputs hold and completion is delayed by exactly 3 cycles.
REQ-042 Half read at 0xFFFFFFFF -> bytes are read from 0xFFFFFFFF then 0x00000000.
